adc_capture_ctrl: RTL and testbench
===================================

Name: adc_capture_ctrl

Overview:
- Parametrised multi-channel ADC capture controller; next generation of the single-channel ADC FIFO/trigger controller.
- Stores CH parallel sample streams in per-channel circular buffers, with a programmable trigger level on a selectable channel and fixed pre-trigger depth.
- After capture, streams the frozen record out channel by channel over a valid/ready port to the display/UART path.

Parameters:
- CH, 4, number of ADC channels (1..8).
- DATA_W, 8, sample width in bits.
- DEPTH, 1024, samples per channel per record; power of two, >= 4.
- PRE_LEN, 256, pre-trigger samples kept; 1 <= PRE_LEN <= DEPTH-1.
- TIMEOUT, 1000000, auto-trigger timeout in cycles; used only with the optional feature.

Ports:
- Clk  in  1  sample clock; one sample per channel per cycle.
- Reset  in  1  asynchronous, active-high reset.
- ADC_Data  in  CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- Trig_Level  in  DATA_W  unsigned trigger threshold.
- Trig_Sel  in  max(1,$clog2(CH))  trigger source channel; values >= CH select channel 0.
- Start  in  1  single-cycle arm request.
- Abort  in  1  cancel capture or readout.
- Busy  out  1  high in any state except IDLE.
- Triggered  out  1  high from trigger acceptance until return to IDLE.
- Rd_Valid  out  1  readout word valid.
- Rd_Ready  in  1  downstream accept.
- Rd_Data  out  DATA_W  readout sample.
- Rd_Chan  out  max(1,$clog2(CH))  channel of Rd_Data.
- Rd_Last  out  1  final word of the record (last sample of channel CH-1).
- Done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset: state IDLE. All outputs 0. Pointers, counters and previous-sample register cleared. Memory contents undefined.
- States: IDLE -> PRE -> ARMED -> POST -> READ -> IDLE. Abort in any state -> IDLE next cycle, clears Rd_Valid and Triggered, no Done.
- IDLE: Start=1 -> PRE, with wr_ptr=0 and pre_cnt=0. Start outside IDLE is ignored.
- PRE/ARMED/POST: every cycle writes all CH samples at wr_ptr. wr_ptr increments modulo DEPTH and wraps freely. prev <= selected channel sample.
- PRE: pre_cnt counts written samples; when pre_cnt reaches PRE_LEN-1 on a write, go to ARMED. No trigger is evaluated in PRE.
- ARMED: trigger = (prev < Trig_Level) && (cur >= Trig_Level), a rising crossing on the selected channel. On trigger:
  - trig_ptr = wr_ptr of this sample;
  - Triggered=1, post_cnt=0 -> POST.
  - A level already above threshold does not trigger; a rising edge is required.
- POST: writes DEPTH-PRE_LEN-1 further samples, then -> READ. Writing stops: the record is the PRE_LEN samples before the trigger, the trigger sample, then the post samples.
- READ: start address = (trig_ptr - PRE_LEN) mod DEPTH. Sequence is channel 0 addresses start..start+DEPTH-1 (mod DEPTH), then channel 1, ... channel CH-1.
  - Memory read has 1-cycle latency; first Rd_Valid appears 2 cycles after entering READ.
  - A word transfers on Rd_Valid && Rd_Ready. While Rd_Valid && !Rd_Ready, Rd_Data, Rd_Chan and Rd_Last hold stable.
  - Sustained Rd_Ready=1 gives one word per cycle (prefetch/skid register required).
  - Rd_Last=1 only on word CH*DEPTH-1. Its transfer -> IDLE with Done=1 for one cycle. Busy falls in the same cycle Done rises.
- Trig_Sel and Trig_Level are sampled every cycle; changing them while ARMED takes effect on the next sample.
- Simultaneous Start and Abort in IDLE: Abort wins, stay IDLE.

Optional Feature:
- Macro ADC_CAP_AUTO_TRIG_EN.
- Defined: a cycle counter starts on ARMED entry. If no trigger occurs within TIMEOUT cycles, a forced trigger is taken on the current sample, identical to a real trigger, and output Auto_Trig (1 bit, added port) is set. Auto_Trig clears on return to IDLE.
- Undefined: no counter and no Auto_Trig port; ARMED waits indefinitely.

Test Plan (CH=2, DATA_W=8, DEPTH=16, PRE_LEN=4, Trig_Sel=0, Trig_Level=10):
- ch0 ramp 0,1,2,... and ch1 = ch0+100; pulse Start at ramp 0 -> Triggered on value 10; readout ch0 6..21, then ch1 106..121; Rd_Last on 121; Done 1 cycle later; 32 words total.
- Same stimulus with ch0 held at 50 -> stays ARMED, no Triggered, Busy=1 indefinitely (ADC_CAP_AUTO_TRIG_EN undefined).
- Crossing at ramp value 2, before PRE completes (Trig_Level=2) -> ignored; the record triggers on the next rising crossing after a wrap of an 8-bit sawtooth.
- Rd_Ready toggled 1,0,0,1 repeatedly -> no lost or duplicated words, data stable while stalled, order identical to the first test.
- Abort asserted on the 5th readout word -> Rd_Valid=0 and Busy=0 next cycle, no Done; a following Start captures a fresh record correctly.
- Reset asserted mid-POST -> all outputs 0 immediately (asynchronous); after release, Start/trigger gives the correct record.

Source files
------------

// File: rtl/adc_capture_ctrl_if.sv
// Readout port of adc_capture_ctrl: one sample per valid/ready transfer.
// master drives Rd_Valid/Rd_Data/Rd_Chan/Rd_Last; slave drives Rd_Ready.
interface adc_capture_ctrl_if #(
    parameter int CH     = 4,
    parameter int DATA_W = 8
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    logic              Rd_Valid;
    logic              Rd_Ready;
    logic [DATA_W-1:0] Rd_Data;
    logic [CW-1:0]     Rd_Chan;
    logic              Rd_Last;

    modport master (
        output Rd_Valid, Rd_Data, Rd_Chan, Rd_Last,
        input  Rd_Ready
    );

    modport slave (
        input  Rd_Valid, Rd_Data, Rd_Chan, Rd_Last,
        output Rd_Ready
    );
endinterface

// File: rtl/adc_capture_ctrl.sv
// Multi-channel ADC capture: per-channel ring buffers, edge trigger with
// pre-trigger history, then channel-by-channel readout over valid/ready.
// Ports: Clk, Reset (async, high), ADC_Data, Trig_Level, Trig_Sel, Start,
// Abort, Busy, Triggered, Done, rd (readout master). Optional macro
// ADC_CAP_AUTO_TRIG_EN adds a timeout auto-trigger and the Auto_Trig port.
module adc_capture_ctrl #(
    parameter int CH      = 4,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 1024,
    parameter int PRE_LEN = 256,
    parameter int TIMEOUT = 1000000
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [CH*DATA_W-1:0]    ADC_Data,
    input  logic [DATA_W-1:0]       Trig_Level,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] Trig_Sel,
    input  logic                    Start,
    input  logic                    Abort,
    output logic                    Busy,
    output logic                    Triggered,
`ifdef ADC_CAP_AUTO_TRIG_EN
    output logic                    Auto_Trig,
`endif
    output logic                    Done,
    adc_capture_ctrl_if.master      rd
);
    localparam int CW       = (CH > 1) ? $clog2(CH) : 1;
    localparam int AW       = $clog2(DEPTH);
    localparam int POST_LEN = DEPTH - PRE_LEN - 1;

    if (CH < 1 || CH > 8 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
        PRE_LEN < 1 || PRE_LEN > DEPTH - 1 || TIMEOUT < 1)
    begin : g_bad_param
        $error("adc_capture_ctrl: illegal parameter set");
    end

    typedef enum logic [2:0] {
        IDLE, PRE, ARMED, POST, READ
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CW-1:0]     chan;
        logic              last;
    } word_t;

    state_t            state;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     pre_cnt;
    logic [AW-1:0]     post_cnt;
    logic [AW-1:0]     trig_ptr;
    logic [DATA_W-1:0] prev;

    logic [AW-1:0]     rd_off;
    logic [CW-1:0]     rd_ch;
    logic              iss_done;
    logic              m_v;
    logic [CW-1:0]     m_chan;
    logic              m_last;
    logic [DATA_W-1:0] mem_q;
    logic              out_v;
    word_t             out_w;
    logic              sk_v;
    word_t             sk_w;

    logic [DATA_W-1:0] mem [CH][DEPTH];

    logic [CW-1:0]     sel_ch;
    logic [DATA_W-1:0] cur;
    logic              trig_hit;
    logic              trig_take;
    logic              wr_en;
    logic              pop;
    logic [1:0]        occ;
    logic              issue;
    logic [AW-1:0]     rd_addr;
    word_t             m_word;

`ifdef ADC_CAP_AUTO_TRIG_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt;
`endif

    always_comb begin
        sel_ch   = (int'(Trig_Sel) < CH) ? CW'(Trig_Sel) : '0;
        cur      = ADC_Data[int'(sel_ch)*DATA_W +: DATA_W];
        trig_hit = (prev < Trig_Level) && (cur >= Trig_Level);
`ifdef ADC_CAP_AUTO_TRIG_EN
        trig_take = trig_hit || (to_cnt == TW'(TIMEOUT - 1));
`else
        trig_take = trig_hit;
`endif
        wr_en   = (state == PRE) || (state == ARMED) || (state == POST);
        rd_addr = (trig_ptr - AW'(PRE_LEN)) + rd_off;
        pop     = out_v && rd.Rd_Ready;
        // Words in flight after this edge; a new read is issued only
        // if its data is guaranteed a slot in the out/skid pair.
        occ     = 2'(out_v) + 2'(sk_v) + 2'(m_v) - 2'(pop);
        issue   = (state == READ) && !iss_done && (occ <= 2'd1);
        m_word  = '{data: mem_q, chan: m_chan, last: m_last};
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            for (int k = 0; k < CH; k++) begin
                mem[k][wr_ptr] <= ADC_Data[k*DATA_W +: DATA_W];
            end
        end
        if (issue) begin
            mem_q <= mem[rd_ch][rd_addr];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            Busy      <= 1'b0;
            Triggered <= 1'b0;
            Done      <= 1'b0;
            wr_ptr    <= '0;
            pre_cnt   <= '0;
            post_cnt  <= '0;
            trig_ptr  <= '0;
            prev      <= '0;
            rd_off    <= '0;
            rd_ch     <= '0;
            iss_done  <= 1'b0;
            m_v       <= 1'b0;
            m_chan    <= '0;
            m_last    <= 1'b0;
            out_v     <= 1'b0;
            out_w     <= '0;
            sk_v      <= 1'b0;
            sk_w      <= '0;
`ifdef ADC_CAP_AUTO_TRIG_EN
            Auto_Trig <= 1'b0;
            to_cnt    <= '0;
`endif
        end else begin
            Done <= 1'b0;
            if (Abort) begin
                state     <= IDLE;
                Busy      <= 1'b0;
                Triggered <= 1'b0;
                m_v       <= 1'b0;
                out_v     <= 1'b0;
                sk_v      <= 1'b0;
`ifdef ADC_CAP_AUTO_TRIG_EN
                Auto_Trig <= 1'b0;
`endif
            end else begin
                unique case (state)
                    IDLE: begin
                        if (Start) begin
                            state   <= PRE;
                            Busy    <= 1'b1;
                            wr_ptr  <= '0;
                            pre_cnt <= '0;
                        end
                    end
                    PRE: begin
                        wr_ptr  <= wr_ptr + 1'b1;
                        prev    <= cur;
                        pre_cnt <= pre_cnt + 1'b1;
                        if (pre_cnt == AW'(PRE_LEN - 1)) begin
                            state <= ARMED;
`ifdef ADC_CAP_AUTO_TRIG_EN
                            to_cnt <= '0;
`endif
                        end
                    end
                    ARMED: begin
                        wr_ptr <= wr_ptr + 1'b1;
                        prev   <= cur;
`ifdef ADC_CAP_AUTO_TRIG_EN
                        to_cnt <= to_cnt + 1'b1;
`endif
                        if (trig_take) begin
                            trig_ptr  <= wr_ptr;
                            Triggered <= 1'b1;
                            post_cnt  <= '0;
`ifdef ADC_CAP_AUTO_TRIG_EN
                            Auto_Trig <= !trig_hit;
`endif
                            // With no post samples the record is
                            // complete at the trigger sample itself.
                            if (POST_LEN == 0) begin
                                state    <= READ;
                                rd_off   <= '0;
                                rd_ch    <= '0;
                                iss_done <= 1'b0;
                                m_v      <= 1'b0;
                            end else begin
                                state <= POST;
                            end
                        end
                    end
                    POST: begin
                        wr_ptr   <= wr_ptr + 1'b1;
                        prev     <= cur;
                        post_cnt <= post_cnt + 1'b1;
                        if (post_cnt == AW'(POST_LEN - 1)) begin
                            state    <= READ;
                            rd_off   <= '0;
                            rd_ch    <= '0;
                            iss_done <= 1'b0;
                            m_v      <= 1'b0;
                        end
                    end
                    READ: begin
                        m_v <= issue;
                        if (issue) begin
                            m_chan <= rd_ch;
                            m_last <= (rd_ch == CW'(CH - 1)) &&
                                      (rd_off == '1);
                            rd_off <= rd_off + 1'b1;
                            if (rd_off == '1) begin
                                rd_ch <= rd_ch + 1'b1;
                                if (rd_ch == CW'(CH - 1)) begin
                                    iss_done <= 1'b1;
                                end
                            end
                        end
                        // out_w is the head, sk_w the skid behind it.
                        if (!out_v || pop) begin
                            if (sk_v) begin
                                out_w <= sk_w;
                                out_v <= 1'b1;
                                sk_v  <= m_v;
                                if (m_v) begin
                                    sk_w <= m_word;
                                end
                            end else begin
                                out_v <= m_v;
                                if (m_v) begin
                                    out_w <= m_word;
                                end
                            end
                        end else if (m_v) begin
                            sk_w <= m_word;
                            sk_v <= 1'b1;
                        end
                        if (pop && out_w.last) begin
                            state     <= IDLE;
                            Busy      <= 1'b0;
                            Triggered <= 1'b0;
                            Done      <= 1'b1;
                            out_v     <= 1'b0;
                            sk_v      <= 1'b0;
                            m_v       <= 1'b0;
`ifdef ADC_CAP_AUTO_TRIG_EN
                            Auto_Trig <= 1'b0;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign rd.Rd_Valid = out_v;
    assign rd.Rd_Data  = out_w.data;
    assign rd.Rd_Chan  = out_w.chan;
    assign rd.Rd_Last  = out_w.last;
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: record-level model of captured samples,
// per-cycle compare process, and literal checks on known records.
module tb_adc_capture_ctrl;
    localparam int CH      = 2;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;
    localparam int PRE_LEN = 4;
    localparam int NW      = CH * DEPTH;
    localparam int HMAX    = 2048;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] ADC_Data = '0;
    logic [7:0]  Trig_Level = 8'd10;
    logic        Trig_Sel = 1'b0;
    logic        Start = 1'b0;
    logic        Abort = 1'b0;
    logic        Busy, Triggered, Done;

    adc_capture_ctrl_if #(.CH(CH), .DATA_W(DATA_W)) rd_if ();

    adc_capture_ctrl #(
        .CH(CH), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .PRE_LEN(PRE_LEN), .TIMEOUT(1000)
    ) dut (
        .Clk(Clk), .Reset(Reset), .ADC_Data(ADC_Data),
        .Trig_Level(Trig_Level), .Trig_Sel(Trig_Sel),
        .Start(Start), .Abort(Abort), .Busy(Busy),
        .Triggered(Triggered), .Done(Done), .rd(rd_if.master)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model state: samples clocked since arming, words seen.
    logic [15:0] hist [HMAX];
    int          hlen = 0;
    bit          active = 0;
    bit          done_exp = 0;
    int          nx = 0;
    int          done_cnt = 0;
    logic [7:0]  got [NW];
    bit          stall_prev = 0;
    logic [7:0]  h_data;
    logic        h_chan, h_last;

    // First sample index that is a rising crossing once the pre-trigger
    // history is full; -1 if none yet.
    function automatic int find_trig();
        for (int i = PRE_LEN; i < hlen; i++) begin
            logic [15:0] a, b;
            a = hist[i-1];
            b = hist[i];
            if (a[7:0] < Trig_Level && b[7:0] >= Trig_Level) return i;
        end
        return -1;
    endfunction

    always @(negedge Clk) begin
        if (Reset) begin
            chk("rst_busy", 32'(Busy), 0);
            chk("rst_valid", 32'(rd_if.Rd_Valid), 0);
            active     = 0;
            done_exp   = 0;
            stall_prev = 0;
        end else begin
            int ti;
            ti = find_trig();
            chk("busy", 32'(Busy), 32'(active));
            chk("triggered", 32'(Triggered), 32'(active && ti >= 0));
            chk("done", 32'(Done), 32'(done_exp));
            if (!active) chk("valid_idle", 32'(rd_if.Rd_Valid), 0);
            if (stall_prev) begin
                chk("stall_valid", 32'(rd_if.Rd_Valid), 1);
                chk("stall_data", 32'(rd_if.Rd_Data), 32'(h_data));
                chk("stall_chan", 32'(rd_if.Rd_Chan), 32'(h_chan));
                chk("stall_last", 32'(rd_if.Rd_Last), 32'(h_last));
            end
            done_exp = 0;
            if (Abort) begin
                active = 0;
            end else if (!active) begin
                if (Start) begin
                    active = 1;
                    hlen   = 0;
                    nx     = 0;
                end
            end else begin
                if (rd_if.Rd_Valid) begin
                    chk("last_flag", 32'(rd_if.Rd_Last),
                        32'(nx == NW - 1));
                    if (ti < 0 || hlen < ti + DEPTH - PRE_LEN) begin
                        chk("early_word", 32'(rd_if.Rd_Valid), 0);
                    end else if (rd_if.Rd_Ready) begin
                        int ch, j;
                        logic [15:0] h;
                        ch = nx / DEPTH;
                        j  = nx % DEPTH;
                        h  = hist[ti - PRE_LEN + j];
                        chk("word_data", 32'(rd_if.Rd_Data),
                            32'(h[ch*8 +: 8]));
                        chk("word_chan", 32'(rd_if.Rd_Chan), 32'(ch));
                        if (nx < NW) got[nx] = rd_if.Rd_Data;
                        nx++;
                        if (rd_if.Rd_Last) begin
                            active   = 0;
                            done_exp = 1;
                            done_cnt++;
                        end
                    end
                end
                if (active && hlen < HMAX) begin
                    hist[hlen] = ADC_Data;
                    hlen++;
                end
            end
            stall_prev = rd_if.Rd_Valid && !rd_if.Rd_Ready && !Abort;
            h_data = rd_if.Rd_Data;
            h_chan = rd_if.Rd_Chan;
            h_last = rd_if.Rd_Last;
        end
    end

    // Stimulus: ch0 = ramp (8-bit sawtooth) or constant 50, ch1 = ch0+100.
    int ramp = 0;
    int mode = 0;
    int rdy_mode = 0;
    int rcnt = 0;

    task automatic drive();
        logic [7:0] c0;
        c0 = (mode == 0) ? 8'(ramp) : 8'd50;
        ADC_Data = {c0 + 8'd100, c0};
        if (rdy_mode == 0) rd_if.Rd_Ready = 1'b1;
        else rd_if.Rd_Ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        ramp++;
        rcnt++;
        drive();
    endtask

    task automatic arm(input int r0);
        ramp = r0;
        drive();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int d0, n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        chk(nm, 32'(done_cnt - d0), 1);
        tick();
        tick();
    endtask

    task automatic check_ramp_record(input string nm);
        chk({nm, "_count"}, 32'(nx), 32'(NW));
        chk({nm, "_w0"}, 32'(got[0]), 6);
        chk({nm, "_w15"}, 32'(got[15]), 21);
        chk({nm, "_w16"}, 32'(got[16]), 106);
        chk({nm, "_w31"}, 32'(got[31]), 121);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_if.Rd_Ready = 1'b1;
        #1 Reset = 1'b1;
        #1;
        chk("reset_busy", 32'(Busy), 0);
        chk("reset_trig", 32'(Triggered), 0);
        chk("reset_done", 32'(Done), 0);
        chk("reset_valid", 32'(rd_if.Rd_Valid), 0);
        tick();
        tick();
        Reset = 1'b0;
        tick();

        // Ramp capture, continuous ready.
        arm(0);
        wait_done("t1_done", 400);
        check_ramp_record("t1");

        // Level above threshold never crosses: stays armed.
        mode = 1;
        arm(0);
        repeat (60) tick();
        chk("t2_busy", 32'(Busy), 1);
        chk("t2_trig", 32'(Triggered), 0);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        chk("t2_abort_busy", 32'(Busy), 0);
        mode = 0;
        tick();

        // Crossing during pre-fill ignored; trigger after wrap at 2.
        Trig_Level = 8'd2;
        arm(0);
        wait_done("t3_done", 700);
        chk("t3_w0", 32'(got[0]), 254);
        chk("t3_w4", 32'(got[4]), 2);
        chk("t3_w16", 32'(got[16]), 98);
        Trig_Level = 8'd10;

        // Backpressure pattern 1,0,0,1.
        rdy_mode = 1;
        arm(0);
        wait_done("t4_done", 600);
        check_ramp_record("t4");
        rdy_mode = 0;

        // Abort on the 5th readout word, then a fresh capture.
        begin
            int n;
            arm(0);
            n = 0;
            while (nx < 4 && n < 400) begin
                tick();
                n++;
            end
            chk("t5_reach4", 32'(nx), 4);
            Abort = 1'b1;
            tick();
            Abort = 1'b0;
            chk("t5_valid", 32'(rd_if.Rd_Valid), 0);
            chk("t5_busy", 32'(Busy), 0);
            repeat (3) tick();
        end
        arm(30);
        wait_done("t5_redo_done", 700);
        check_ramp_record("t5");

        // Asynchronous reset mid-post.
        begin
            int n;
            arm(0);
            n = 0;
            while (!Triggered && n < 100) begin
                tick();
                n++;
            end
            chk("t6_trig", 32'(Triggered), 1);
            repeat (3) tick();
            Reset = 1'b1;
            #1;
            chk("t6_busy", 32'(Busy), 0);
            chk("t6_trig0", 32'(Triggered), 0);
            chk("t6_valid", 32'(rd_if.Rd_Valid), 0);
            chk("t6_done", 32'(Done), 0);
            tick();
            Reset = 1'b0;
            tick();
        end
        arm(0);
        wait_done("t6_redo_done", 400);
        check_ramp_record("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
